alu_seq_ctrl: RTL

- Sequencing controller that sits between the decode stage and the 32-bit ALU datapath.
- Accepts one operation at a time over a valid/ready handshake and returns one registered result over a valid/ready handshake.
- Runs MUL as an iterative 32-cycle shift-add; every other operation completes in one cycle.
- Holds the architectural Z/N/C/V flags and resolves the six conditional jumps from them.

---
 rtl/alu_seq_ctrl.sv | 120 ++++++++++++
 1 files changed

// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: handshake sequencer for the ALU with iterative MUL, flag register and jump resolution
module alu_seq_ctrl #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         op_valid,
    output logic         op_ready,
    input  logic [4:0]   op_ctrl,
    input  logic [N-1:0] op_a,
    input  logic [N-1:0] op_b,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [N-1:0] res_data,
    output logic         res_taken,
    output logic         res_err,
    output logic [3:0]   flags,
    output logic         busy
);
    localparam int CW = $clog2(N);
    typedef enum logic [1:0] {IDLE, EXEC, MUL, DONE} state_t;
    state_t         state;
    logic [4:0]     code;
    logic [N-1:0]   a, b, acc, mcand, mplier, acc_next, exec_res;
    logic [CW-1:0]  cnt;
    logic [N:0]     sum, diff;
    logic           exec_err, exec_taken, fz, fn, fv, v_add, v_sub;
    logic [3:0]     exec_flags;
    assign fz = flags[3];
    assign fn = flags[2];
    assign fv = flags[0];
    assign op_ready = state == IDLE;
    assign busy = state != IDLE;
    assign sum = {1'b0, a} + {1'b0, b};
    assign diff = {1'b0, a} - {1'b0, b};
    assign v_add = (a[N-1] == b[N-1]) && (sum[N-1] != a[N-1]);
    assign v_sub = (a[N-1] != b[N-1]) && (diff[N-1] != a[N-1]);
    assign acc_next = acc + (mplier[0] ? mcand : '0);
    always_comb begin
        exec_res = '0;
        exec_err = 1'b0;
        exec_taken = 1'b0;
        case (code)
            5'd1, 5'd17, 5'd19: exec_res = sum[N-1:0];
            5'd2:  exec_res = diff[N-1:0];
            5'd4:  exec_res = a;
            5'd9:  exec_res = a & b;
            5'd10: exec_res = a | b;
            5'd11: exec_res = a ^ b;
            5'd12: exec_res = ~a;
            5'd25: begin exec_res = a; exec_taken = fz; end
            5'd26: begin exec_res = a; exec_taken = !fz; end
            5'd27: begin exec_res = a; exec_taken = !fz && (fn == fv); end
            5'd28: begin exec_res = a; exec_taken = fn == fv; end
            5'd29: begin exec_res = a; exec_taken = fn != fv; end
            5'd30: begin exec_res = a; exec_taken = fz || (fn != fv); end
            default: exec_err = 1'b1;
        endcase
        // sub reports C as "no borrow", i.e. A >= B unsigned
        exec_flags = code == 5'd1 ? {sum[N-1:0] == '0, sum[N-1], sum[N], v_add} :
                     code == 5'd2 ? {diff[N-1:0] == '0, diff[N-1], !diff[N], v_sub} : flags;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_taken <= 1'b0;
            res_err   <= 1'b0;
            flags     <= 4'b0000;
            cnt       <= '0;
            code      <= '0;
            a         <= '0;
            b         <= '0;
            acc       <= '0;
            mcand     <= '0;
            mplier    <= '0;
        end else begin
            case (state)
                IDLE: if (op_valid) begin
                    code   <= op_ctrl;
                    a      <= op_a;
                    b      <= op_b;
                    acc    <= '0;
                    mcand  <= op_a;
                    mplier <= op_b;
                    cnt    <= '0;
                    state  <= op_ctrl == 5'd3 ? MUL : EXEC;
                end
                EXEC: begin
                    res_data  <= exec_res;
                    res_taken <= exec_taken;
                    res_err   <= exec_err;
                    flags     <= exec_flags;
                    res_valid <= 1'b1;
                    state     <= DONE;
                end
                MUL: begin
                    acc    <= acc_next;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 1'b1;
                    if (cnt == CW'(N - 1)) begin
                        res_data  <= acc_next;
                        res_taken <= 1'b0;
                        res_err   <= 1'b0;
                        flags     <= {acc_next == '0, acc_next[N-1], flags[1:0]};
                        res_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: if (res_ready) begin
                    res_valid <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
